// File: rtl/uart_rx_core_if.sv
// Host-side result bus of the UART receiver: data word, one-cycle strobe, status.
// master: driven by uart_rx_core; slave: consumed by the host register/FIFO.
interface uart_rx_core_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] o_dout;
  logic                  o_valid;
  logic [1:0]            o_error;

  modport master (output o_dout, output o_valid, output o_error);
  modport slave  (input  o_dout, input  o_valid, input  o_error);
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver core: 8N1 frames (8E1 when UART_RX_PARITY_EN is defined) on i_RX,
// timed by an external x16 oversample tick that this block gates via o_baud_x16_en.
// Each frame is presented as a one-cycle o_valid strobe with o_dout and o_error
// ([0]=framing, [1]=parity), all carried on the uart_rx_core_if master modport.
module uart_rx_core #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  output logic           o_baud_x16_en,
  input  logic           i_baud_x16,
  input  logic           i_RX,
  uart_rx_core_if.master o_rx
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] MID_START = CNT_W'(7);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(15);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_RX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t                r_state, w_state;
  logic [CNT_W-1:0]      r_cnt, w_cnt;
  logic [BIT_W-1:0]      r_bit_idx, w_bit_idx;
  logic [DATA_WIDTH-1:0] r_shift, w_shift;
  logic [DATA_WIDTH-1:0] r_dout, w_dout;
  logic [1:0]            r_error, w_error;
  logic                  r_valid, w_valid;
  logic                  r_baud_en;
  logic                  r_rx_meta, r_rx_s, r_rx_prev;
  logic                  w_tick;
  logic                  w_perr;
`ifdef UART_RX_PARITY_EN
  logic                  r_perr, w_perr_nxt;
`endif

  // Ticks only count while the baud generator has been asked to run
  assign w_tick = i_baud_x16 & r_baud_en;

`ifdef UART_RX_PARITY_EN
  assign w_perr = r_perr;
`else
  assign w_perr = 1'b0;
`endif

  // Two-flop synchroniser plus previous sample for start-edge detection
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= i_RX;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_dout    <= '0;
      r_error   <= '0;
      r_valid   <= 1'b0;
      r_baud_en <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr    <= 1'b0;
`endif
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_bit_idx <= w_bit_idx;
      r_shift   <= w_shift;
      r_dout    <= w_dout;
      r_error   <= w_error;
      r_valid   <= w_valid;
      r_baud_en <= (w_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
      r_perr    <= w_perr_nxt;
`endif
    end
  end

  // Next-state and next-output logic; the counter restarts on every state change
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_bit_idx = r_bit_idx;
    w_shift   = r_shift;
    w_dout    = r_dout;
    w_error   = r_error;
    w_valid   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_perr_nxt = r_perr;
`endif
    if (w_tick) begin
      w_cnt = r_cnt + 1'b1;
    end
    case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        if (r_rx_prev && !r_rx_s) begin
          w_state = S_START;
        end
      end
      S_START: begin
        if (w_tick && (r_cnt == MID_START)) begin
          w_cnt     = '0;
          w_bit_idx = '0;
          w_state   = r_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_tick && (r_cnt == LAST_TICK)) begin
          w_cnt   = '0;
          w_shift = {r_rx_s, r_shift[DATA_WIDTH-1:1]};
          if (r_bit_idx == LAST_BIT) begin
            w_bit_idx = '0;
`ifdef UART_RX_PARITY_EN
            w_state   = S_PARITY;
`else
            w_state   = S_STOP;
`endif
          end else begin
            w_bit_idx = r_bit_idx + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_tick && (r_cnt == LAST_TICK)) begin
          w_cnt      = '0;
          w_perr_nxt = r_rx_s ^ (^r_shift);
          w_state    = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_tick && (r_cnt == LAST_TICK)) begin
          w_cnt   = '0;
          w_dout  = r_shift;
          w_error = {w_perr, ~r_rx_s};
          w_valid = 1'b1;
          w_state = S_IDLE;
        end
      end
      default: begin
        w_cnt   = '0;
        w_state = S_IDLE;
      end
    endcase
  end

  assign o_baud_x16_en = r_baud_en;
  assign o_rx.o_dout   = r_dout;
  assign o_rx.o_valid  = r_valid;
  assign o_rx.o_error  = r_error;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: fractional x16 baud tick (13 + 6/16 clocks) gated by
// o_baud_x16_en, a bit-serial transmitter on i_RX, and a scoreboard of expected
// {data, error} words that is drained as o_valid strobes arrive.
module tb_uart_rx_core;

  localparam int BIT_CLKS = 214;   // 16 * 13.375 clocks per bit
  localparam int TIMEOUT  = 100000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rx = 1'b1;
  logic tick = 1'b0;
  logic baud_en;

  uart_rx_core_if #(.DATA_WIDTH(8)) rx_if ();

  uart_rx_core #(.DATA_WIDTH(8)) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .o_baud_x16_en (baud_en),
    .i_baud_x16    (tick),
    .i_RX          (rx),
    .o_rx          (rx_if)
  );

  always #20 clk = ~clk;

  // Baud generator model: divisor 13 with 6/16 fractional adjust, held while disabled
  int bg_cnt = 0;
  int bg_acc = 0;
  always @(posedge clk) begin
    if (!baud_en) begin
      bg_cnt <= 0;
      bg_acc <= 0;
      tick   <= 1'b0;
    end else if (bg_cnt == 0) begin
      tick   <= 1'b1;
      bg_cnt <= (bg_acc + 6 >= 16) ? 13 : 12;
      bg_acc <= (bg_acc + 6) % 16;
    end else begin
      tick   <= 1'b0;
      bg_cnt <= bg_cnt - 1;
    end
  end

  // Monitor: capture every strobe
  logic [9:0] obs_q[$];
  logic [9:0] exp_q[$];
  int v_cnt = 0;
  always @(negedge clk) begin
    if (rx_if.o_valid === 1'b1) begin
      v_cnt++;
      obs_q.push_back({rx_if.o_dout, rx_if.o_error});
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // Transmit one frame and push its expected {data, perr, ferr} result
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    logic perr_exp;
`ifdef UART_RX_PARITY_EN
    perr_exp = par_flip;
`else
    perr_exp = 1'b0 & par_flip;
`endif
    exp_q.push_back({d, perr_exp, ~stop});
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`endif
    drive_bit(stop);
  endtask

  // Pop the next strobe (bounded wait) and compare with the scoreboard head
  task automatic check_next(input string tag);
    int waited = 0;
    logic [9:0] exp_v;
    exp_v = exp_q.pop_front();
    while (obs_q.size() == 0 && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    if (obs_q.size() == 0) check({tag, "_timeout"}, 32'(obs_q.size()), 1);
    else check(tag, 32'(obs_q.pop_front()), 32'(exp_v));
  endtask

  int v_base;

  initial begin
    // Reset with line idle
    repeat (5) @(negedge clk);
    check("rst_valid", 32'(rx_if.o_valid), 0);
    check("rst_dout", 32'(rx_if.o_dout), 0);
    rstn = 1'b1;
    repeat (1000) @(negedge clk);
    check("idle_no_valid", 32'(v_cnt), 0);
    check("idle_dout", 32'(rx_if.o_dout), 0);
    check("idle_error", 32'(rx_if.o_error), 0);
    check("idle_baud_en", 32'(baud_en), 0);

    // Back-to-back frames
    v_base = v_cnt;
    send_frame(8'hA6, 1'b1, 1'b0);
    send_frame(8'h37, 1'b1, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    check_next("b2b_A6");
    check_next("b2b_37");
    check_next("b2b_00");
    check_next("b2b_FF");
    repeat (500) @(negedge clk);
    check("b2b_strobe_count", 32'(v_cnt - v_base), 4);
    check("b2b_leftover", 32'(obs_q.size()), 0);

    // Short low glitch: start detected, rejected at mid-start
    v_base = v_cnt;
    rx = 1'b0;
    repeat (54) @(negedge clk);
    check("glitch_en_hi", 32'(baud_en), 1);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch_en_lo", 32'(baud_en), 0);
    check("glitch_no_valid", 32'(v_cnt - v_base), 0);
    send_frame(8'h55, 1'b1, 1'b0);
    check_next("after_glitch_55");

    // Stop bit low, line then held low (break)
    repeat (BIT_CLKS) @(negedge clk);
    v_base = v_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    check_next("break_3C");
    repeat (3000) @(negedge clk);
    check("break_single_strobe", 32'(v_cnt - v_base), 1);
    check("break_hold_error", 32'(rx_if.o_error), 32'h1);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    // Parity: 0x07 needs parity bit 1 for even parity
    send_frame(8'h07, 1'b1, 1'b1);
    check_next("par_bad_07");
    send_frame(8'h07, 1'b1, 1'b0);
    check_next("par_good_07");
    repeat (BIT_CLKS) @(negedge clk);
`endif

    // Reset in the middle of the data bits
    v_base = v_cnt;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    repeat (100) @(negedge clk);
    rstn = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    repeat (3000) @(negedge clk);
    check("midrst_no_valid", 32'(v_cnt - v_base), 0);
    check("midrst_dout", 32'(rx_if.o_dout), 0);
    check("midrst_error", 32'(rx_if.o_error), 0);
    check("midrst_baud_en", 32'(baud_en), 0);
    send_frame(8'h81, 1'b1, 1'b0);
    check_next("after_rst_81");
    repeat (500) @(negedge clk);
    check("final_leftover", 32'(obs_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
